// File: rtl/imm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_pkg                                                                    |
// | Widths and operand-interpretation mode shared by the immediate units.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package imm_pkg;

  localparam int IMM_N_DEFAULT = 16;
  localparam int IMM_M_DEFAULT = 32;

  typedef enum logic {
    IMM_SIGNED   = 1'b0,
    IMM_UNSIGNED = 1'b1
  } imm_mode_t;

endpackage
`default_nettype wire

// File: rtl/imm_range_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_range_check                                                            |
// | Combinational fit test and narrowed value; IMM_SATURATE_EN enables clamp.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module imm_range_check
  import imm_pkg::*;
#(
  parameter int N = IMM_N_DEFAULT,
  parameter int M = IMM_M_DEFAULT
) (
  input  logic [M-1:0] i_value,
  input  logic         i_u,
  output logic         o_fit,
  output logic [N-1:0] o_sat_value
);

  imm_mode_t    w_mode;
  logic [M-N:0] w_sign_field;
  logic         w_fit_signed;
  logic         w_fit_unsigned;

  assign w_mode         = imm_mode_t'(i_u);
  // Signed fit needs every bit from the new sign position upward to agree.
  assign w_sign_field   = i_value[M-1:N-1];
  assign w_fit_signed   = (&w_sign_field) | ~(|w_sign_field);
  assign w_fit_unsigned = ~(|i_value[M-1:N]);
  assign o_fit          = (w_mode == IMM_UNSIGNED) ? w_fit_unsigned : w_fit_signed;

`ifdef IMM_SATURATE_EN
  logic [N-1:0] w_clamp;

  always_comb begin
    w_clamp = '1;
    if (w_mode == IMM_SIGNED) begin
      w_clamp = i_value[M-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end

  assign o_sat_value = o_fit ? i_value[N-1:0] : w_clamp;
`else
  assign o_sat_value = i_value[N-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/immediate_narrowing_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | immediate_narrowing_unit                                                   |
// | Two-stage valid/ready narrowing pipe with overflow counter.                |
// | Optional clamp of out-of-range results: define IMM_SATURATE_EN.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module immediate_narrowing_unit
  import imm_pkg::*;
#(
  parameter int N     = IMM_N_DEFAULT,
  parameter int M     = IMM_M_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     in_value,
  input  logic             in_u,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_imm,
  output logic             out_fit,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             cnt_clr
);

  logic             r_live;
  logic             r_s1_valid;
  logic [M-1:0]     r_s1_value;
  logic             r_s1_u;
  logic             r_s2_valid;
  logic [N-1:0]     r_s2_imm;
  logic             r_s2_fit;
  logic [CNT_W-1:0] r_ovf_count;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_fit;
  logic [N-1:0]     w_imm;

  assign w_s2_adv   = ~r_s2_valid | out_ready;
  assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
  // r_live keeps the input closed until the first edge after reset release.
  assign in_ready   = r_live & w_s1_adv;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_s2_valid & out_ready;

  imm_range_check #(
    .N (N),
    .M (M)
  ) u_range_check (
    .i_value     (r_s1_value),
    .i_u         (r_s1_u),
    .o_fit       (w_fit),
    .o_sat_value (w_imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live     <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_value <= '0;
      r_s1_u     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_s1_adv) begin
        r_s1_valid <= w_in_fire;
      end
      if (w_in_fire) begin
        r_s1_value <= in_value;
        r_s1_u     <= in_u;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_imm   <= '0;
      r_s2_fit   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_imm <= w_imm;
        r_s2_fit <= w_fit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_count <= '0;
    end else if (cnt_clr) begin
      r_ovf_count <= '0;
    end else if (w_out_fire && !r_s2_fit && !(&r_ovf_count)) begin
      r_ovf_count <= r_ovf_count + CNT_W'(1);
    end
  end

  assign out_valid = r_s2_valid;
  assign out_imm   = r_s2_imm;
  assign out_fit   = r_s2_fit;
  assign ovf_count = r_ovf_count;

endmodule
`default_nettype wire
